pong_game_ctrl: RTL and testbench

Game-flow sequencer for the Pong top level. Owns the serve/play/point/game-over state machine, the two player scores, and the frame-paced delays between rallies. Gates the paddle and ball controllers through play-enable, ball-reset and serve-direction outputs. Feeds the 7-segment score displays.

---
 rtl/pong_game_ctrl.sv | 146 ++++++++++++++
 tb/tb_pong_game_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: serve/play/point/over FSM, scores and frame-paced delays.
// Optional pause feature is compiled in with `define PONG_PAUSE_EN.
//
// state | meaning
// IDLE  | power-up, waiting for start, ball held at centre
// SERVE | ball held at centre for SERVE_FRAMES frames
// PLAY  | rally in progress, paddles and ball move
// POINT | pause of POINT_FRAMES frames after a point
// OVER  | a player reached SCORE_LIMIT, waiting for start
// PAUSE | rally frozen in place (PONG_PAUSE_EN only)
module pong_game_ctrl #(
   parameter int SCORE_LIMIT  = 9,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 120
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Frame_Start,
   input  logic       i_Start,
   input  logic       i_Ball_Out_P1,
   input  logic       i_Ball_Out_P2,
`ifdef PONG_PAUSE_EN
   input  logic       i_Pause,
`endif
   output logic       o_Play_En,
   output logic       o_Ball_Reset,
   output logic       o_Serve_Dir,
   output logic [3:0] o_P1_Score,
   output logic [3:0] o_P2_Score,
   output logic       o_Game_Over,
   output logic       o_Winner,
   output logic [2:0] o_State
);

   localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

   localparam logic [CNT_W-1:0] SERVE_TC = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0] POINT_TC = CNT_W'(POINT_FRAMES - 1);
   localparam logic [3:0]       LIMIT    = 4'(SCORE_LIMIT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4,
      PAUSE = 3'd5
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       p1_nxt, p2_nxt;
   logic             dir_nxt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      p1_nxt    = o_P1_Score;
      p2_nxt    = o_P2_Score;
      dir_nxt   = o_Serve_Dir;
      case (state)
         IDLE: begin
            p1_nxt = '0;
            p2_nxt = '0;
            if (i_Start) state_nxt = SERVE;
         end
         SERVE: begin
            if (i_Frame_Start) begin
               if (cnt == SERVE_TC) state_nxt = PLAY;
               else                 cnt_nxt   = cnt + CNT_W'(1);
            end
         end
         PLAY: begin
            // ball-out outranks start/pause; a double ball-out replays the rally
            if (i_Ball_Out_P1 && i_Ball_Out_P2) begin
               state_nxt = POINT;
            end else if (i_Ball_Out_P1) begin
               if (o_P2_Score < LIMIT) p2_nxt = o_P2_Score + 4'd1;
               dir_nxt   = 1'b0;
               state_nxt = POINT;
            end else if (i_Ball_Out_P2) begin
               if (o_P1_Score < LIMIT) p1_nxt = o_P1_Score + 4'd1;
               dir_nxt   = 1'b1;
               state_nxt = POINT;
            end
`ifdef PONG_PAUSE_EN
            else if (i_Pause) begin
               state_nxt = PAUSE;
            end
`endif
         end
         POINT: begin
            if (i_Frame_Start) begin
               if (cnt == POINT_TC)
                  state_nxt = (o_P1_Score == LIMIT || o_P2_Score == LIMIT) ? OVER : SERVE;
               else
                  cnt_nxt = cnt + CNT_W'(1);
            end
         end
         OVER: begin
            if (i_Start) begin
               p1_nxt    = '0;
               p2_nxt    = '0;
               state_nxt = SERVE;
            end
         end
`ifdef PONG_PAUSE_EN
         PAUSE: begin
            if (i_Pause) state_nxt = PLAY;
         end
`endif
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
   end

   // outputs are decoded from next-state so they land in the same register stage as the state
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state        <= IDLE;
         cnt          <= '0;
         o_P1_Score   <= '0;
         o_P2_Score   <= '0;
         o_Serve_Dir  <= 1'b0;
         o_Play_En    <= 1'b0;
         o_Ball_Reset <= 1'b1;
         o_Game_Over  <= 1'b0;
         o_Winner     <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         o_P1_Score   <= p1_nxt;
         o_P2_Score   <= p2_nxt;
         o_Serve_Dir  <= dir_nxt;
         o_Play_En    <= (state_nxt == PLAY);
         o_Ball_Reset <= (state_nxt == IDLE) || (state_nxt == SERVE) ||
                         (state_nxt == POINT) || (state_nxt == OVER);
         o_Game_Over  <= (state_nxt == OVER);
         o_Winner     <= (state_nxt == OVER) && (p2_nxt == LIMIT);
      end
   end

   assign o_State = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl with SCORE_LIMIT=3 and default frame delays.
module tb_pong_game_ctrl;

   logic       i_Clk = 1'b0;
   logic       i_Rst_L = 1'b0;
   logic       i_Frame_Start = 1'b0;
   logic       i_Start = 1'b0;
   logic       i_Ball_Out_P1 = 1'b0;
   logic       i_Ball_Out_P2 = 1'b0;
   logic       i_Pause = 1'b0;
   logic       o_Play_En, o_Ball_Reset, o_Serve_Dir, o_Game_Over, o_Winner;
   logic [3:0] o_P1_Score, o_P2_Score;
   logic [2:0] o_State;

   pong_game_ctrl #(.SCORE_LIMIT(3), .SERVE_FRAMES(60), .POINT_FRAMES(120)) dut (
      .i_Clk         (i_Clk),
      .i_Rst_L       (i_Rst_L),
      .i_Frame_Start (i_Frame_Start),
      .i_Start       (i_Start),
      .i_Ball_Out_P1 (i_Ball_Out_P1),
      .i_Ball_Out_P2 (i_Ball_Out_P2),
`ifdef PONG_PAUSE_EN
      .i_Pause       (i_Pause),
`endif
      .o_Play_En     (o_Play_En),
      .o_Ball_Reset  (o_Ball_Reset),
      .o_Serve_Dir   (o_Serve_Dir),
      .o_P1_Score    (o_P1_Score),
      .o_P2_Score    (o_P2_Score),
      .o_Game_Over   (o_Game_Over),
      .o_Winner      (o_Winner),
      .o_State       (o_State)
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] p1;
      logic [3:0] p2;
      logic       play;
      logic       brst;
      logic       dir;
      logic       over;
      logic       win;
   } snap_t;

   snap_t exp_q[$];
   snap_t got, want;
   int    checks = 0;
   int    errors = 0;

   // expected output vector for a given state/score/direction
   function automatic snap_t mk(input logic [2:0] st, input logic [3:0] p1, input logic [3:0] p2,
                                input logic dir, input logic win);
      snap_t s;
      s.st   = st;
      s.p1   = p1;
      s.p2   = p2;
      s.play = (st == 3'd2);
      s.brst = (st == 3'd0) || (st == 3'd1) || (st == 3'd3) || (st == 3'd4);
      s.dir  = dir;
      s.over = (st == 3'd4);
      s.win  = (st == 3'd4) ? win : 1'b0;
      return s;
   endfunction

   function automatic snap_t observe();
      return {o_State, o_P1_Score, o_P2_Score, o_Play_En, o_Ball_Reset, o_Serve_Dir,
              o_Game_Over, o_Winner};
   endfunction

   // drive one cycle of inputs starting at a negedge; outputs are settled at the next negedge
   task automatic step(input bit f, input bit s, input bit b1, input bit b2, input bit p);
      i_Frame_Start = f;
      i_Start       = s;
      i_Ball_Out_P1 = b1;
      i_Ball_Out_P2 = b2;
      i_Pause       = p;
      @(negedge i_Clk);
      i_Frame_Start = 1'b0;
      i_Start       = 1'b0;
      i_Ball_Out_P1 = 1'b0;
      i_Ball_Out_P2 = 1'b0;
      i_Pause       = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      i_Rst_L = 1'b0;
      repeat (3) @(negedge i_Clk);
      exp_q.push_back(mk(3'd0, 4'd0, 4'd0, 1'b0, 1'b0));
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset_held got=%h want=%h", got, want); end
      i_Rst_L = 1'b1;
      exp_q.push_back(mk(3'd0, 4'd0, 4'd0, 1'b0, 1'b0));
      step(1, 0, 1, 1, 0);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL idle_ignores got=%h want=%h", got, want); end
   endtask

   task automatic test_serve(input logic [3:0] p1, input logic [3:0] p2, input logic dir);
      exp_q.push_back(mk(3'd1, p1, p2, dir, 1'b0));
      step(0, 1, 0, 0, 0);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL serve_entry got=%h want=%h", got, want); end
      exp_q.push_back(mk(3'd1, p1, p2, dir, 1'b0));
      frames(59);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL serve_frame59 got=%h want=%h", got, want); end
      exp_q.push_back(mk(3'd2, p1, p2, dir, 1'b0));
      frames(1);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL serve_to_play got=%h want=%h", got, want); end
   endtask

   task automatic test_point_p2();
      exp_q.push_back(mk(3'd3, 4'd0, 4'd1, 1'b0, 1'b0));
      step(0, 0, 1, 0, 0);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL point_p2 got=%h want=%h", got, want); end
      exp_q.push_back(mk(3'd3, 4'd0, 4'd1, 1'b0, 1'b0));
      frames(119);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL point_frame119 got=%h want=%h", got, want); end
      exp_q.push_back(mk(3'd1, 4'd0, 4'd1, 1'b0, 1'b0));
      frames(1);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL point_to_serve got=%h want=%h", got, want); end
   endtask

   task automatic test_serve_ignore_and_async_reset();
      exp_q.push_back(mk(3'd1, 4'd0, 4'd1, 1'b0, 1'b0));
      frames(30);
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL serve_ignores got=%h want=%h", got, want); end
      exp_q.push_back(mk(3'd0, 4'd0, 4'd0, 1'b0, 1'b0));
      #2 i_Rst_L = 1'b0;
      #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL async_reset got=%h want=%h", got, want); end
      @(negedge i_Clk);
      i_Rst_L = 1'b1;
      @(negedge i_Clk);
   endtask

   task automatic test_replay_and_boundary();
      exp_q.push_back(mk(3'd3, 4'd0, 4'd0, 1'b0, 1'b0));
      step(0, 0, 1, 1, 0);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL replay got=%h want=%h", got, want); end
      frames(120);
      // ball-out on the SERVE exit cycle is judged against SERVE and ignored
      exp_q.push_back(mk(3'd2, 4'd0, 4'd0, 1'b0, 1'b0));
      frames(59);
      step(1, 0, 0, 1, 0);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL serve_exit_ballout got=%h want=%h", got, want); end
   endtask

   task automatic test_game_over();
      for (int r = 1; r <= 3; r++) begin
         exp_q.push_back(mk(3'd3, 4'(r), 4'd0, 1'b1, 1'b0));
         step(0, 1, 0, 1, 1);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL rally%0d_p1 got=%h want=%h", r, got, want); end
         if (r < 3) frames(180);
      end
      exp_q.push_back(mk(3'd3, 4'd3, 4'd0, 1'b1, 1'b0));
      frames(119);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL last_point_hold got=%h want=%h", got, want); end
      exp_q.push_back(mk(3'd4, 4'd3, 4'd0, 1'b1, 1'b0));
      frames(1);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL game_over got=%h want=%h", got, want); end
      exp_q.push_back(mk(3'd4, 4'd3, 4'd0, 1'b1, 1'b0));
      step(1, 0, 1, 0, 0);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL over_ignores got=%h want=%h", got, want); end
      // serve direction survives the new game
      test_serve(4'd0, 4'd0, 1'b1);
   endtask

`ifdef PONG_PAUSE_EN
   task automatic test_pause();
      exp_q.push_back(mk(3'd5, 4'd0, 4'd0, 1'b1, 1'b0));
      step(0, 0, 0, 0, 1);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pause_enter got=%h want=%h", got, want); end
      exp_q.push_back(mk(3'd5, 4'd0, 4'd0, 1'b1, 1'b0));
      step(1, 1, 1, 0, 0);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pause_ignores got=%h want=%h", got, want); end
      exp_q.push_back(mk(3'd2, 4'd0, 4'd0, 1'b1, 1'b0));
      step(0, 0, 0, 0, 1);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pause_exit got=%h want=%h", got, want); end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      @(negedge i_Clk);
      test_reset();
      test_serve(4'd0, 4'd0, 1'b0);
      test_point_p2();
      test_serve_ignore_and_async_reset();
      test_serve(4'd0, 4'd0, 1'b0);
      test_replay_and_boundary();
      test_game_over();
`ifdef PONG_PAUSE_EN
      test_pause();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
